// File: rtl/echo_engine_if.sv
// Sample/config/status bundle between the audio front end and echo_engine.
// The engine takes the slave side; the sample source and sink take the master side.
interface echo_engine_if #(
  parameter int DW = 10,
  parameter int AW = 13
);
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic [AW-1:0] delay;
  logic          mode;
  logic [1:0]    gain_sel;
  logic [DW-1:0] data_out;
  logic          out_valid;
  logic          busy;
  logic          overrun;

  modport master (
    output data_in, data_valid, delay, mode, gain_sel,
    input  data_out, out_valid, busy, overrun
  );

  modport slave (
    input  data_in, data_valid, delay, mode, gain_sel,
    output data_out, out_valid, busy, overrun
  );
endinterface

// File: rtl/echo_engine.sv
// Single-tap echo/reverb over a 2^AW delay RAM; out_valid 4 edges after accepted data_valid.
// No backpressure: data_valid while a sample is in flight is dropped and sets sticky overrun.
module echo_engine #(
  parameter int DW = 10,
  parameter int AW = 13
) (
  input  logic         sysclk,
  input  logic         rst_n,
  echo_engine_if.slave io
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CALC,
    S_OUT
  } state_t;

  state_t               state_q, state_d;
  logic signed [DW-1:0] x_q, x_d;
  logic signed [DW-1:0] y_q, y_d;
  logic [AW-1:0]        dly_q, dly_d;
  logic                 mode_q, mode_d;
  logic [1:0]           gain_q, gain_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        fill_q, fill_d;
  logic [DW-1:0]        data_out_q, data_out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;

  logic [DW-1:0]        mem [DEPTH];
  logic [DW-1:0]        rd_dat_q;
  logic [AW-1:0]        rd_addr;
  logic                 ram_we;
  logic [DW-1:0]        wr_dat;

  logic                 in_flight;
  logic                 accept;
  logic [2:0]           sh;
  logic signed [DW-1:0] tap;
  logic signed [DW-1:0] e;
  logic signed [DW:0]   sum;
  logic signed [DW-1:0] y_calc;

  // An AW-bit delay can never exceed DEPTH-1, so the clamp is inherent in the width.
  assign rd_addr   = wr_ptr_q - dly_q;
  assign in_flight = (state_q != S_IDLE) || busy_q;
  assign accept    = io.data_valid && !in_flight;

  always_comb begin
    sh  = {1'b0, gain_q} + 3'd1;
    tap = '0;
    if (dly_q != '0 && fill_q >= dly_q) begin
      tap = $signed(rd_dat_q);
    end
    e   = tap >>> sh;
    sum = {x_q[DW-1], x_q} + {e[DW-1], e};
    if (sum[DW] != sum[DW-1]) begin
      y_calc = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      y_calc = sum[DW-1:0];
    end
    if (dly_q == '0) begin
      y_calc = x_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dly_d       = dly_q;
    mode_d      = mode_q;
    gain_d      = gain_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    busy_d      = (state_q != S_IDLE);
    overrun_d   = overrun_q | (io.data_valid & in_flight);
    ram_we      = 1'b0;
    wr_dat      = mode_q ? y_calc : x_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Offset-binary to two's complement is an MSB flip.
          x_d     = {~io.data_in[DW-1], io.data_in[DW-2:0]};
          dly_d   = io.delay;
          mode_d  = io.mode;
          gain_d  = io.gain_sel;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: state_d = S_CALC;
      S_CALC: begin
        y_d      = y_calc;
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        fill_d   = (fill_q == '1) ? fill_q : fill_q + AW'(1);
        state_d  = S_OUT;
      end
      S_OUT: begin
        data_out_d  = {~y_q[DW-1], y_q[DW-2:0]};
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      dly_q       <= '0;
      mode_q      <= 1'b0;
      gain_q      <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      data_out_q  <= {1'b1, {(DW-1){1'b0}}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dly_q       <= dly_d;
      mode_q      <= mode_d;
      gain_q      <= gain_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  // Delay RAM is deliberately left out of reset; fill_q gates stale reads.
  always_ff @(posedge sysclk) begin
    if (ram_we) begin
      mem[wr_ptr_q] <= wr_dat;
    end
    rd_dat_q <= mem[rd_addr];
  end

  assign io.data_out  = data_out_q;
  assign io.out_valid = out_valid_q;
  assign io.busy      = busy_q;
  assign io.overrun   = overrun_q;

endmodule

// File: tb/tb_echo_engine.sv
// Directed bench for echo_engine: reset, pass-through, echo, reverb, saturation, wrap, overrun.
// Expected outputs are hand-computed constants.
module tb_echo_engine;

  logic clk;
  logic rst_n;

  echo_engine_if #(.DW(10), .AW(13)) bus ();

  echo_engine #(.DW(10), .AW(13)) dut (
    .sysclk (clk),
    .rst_n  (rst_n),
    .io     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests_run;
  int tests_failed;
  int timeouts;
  int res;
  int lat;
  int busy_cnt;
  int post_ov;
  int post_busy;

  int in3  [6] = '{612, 512, 512, 512, 512, 512};
  int exp3 [6] = '{612, 512, 512, 562, 512, 512};
  int in4  [7] = '{612, 512, 512, 512, 512, 512, 512};
  int exp4 [7] = '{612, 512, 562, 512, 537, 512, 524};

  task automatic chk(input string tag, input int obs, input int expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input int din, input int dly, input int md, input int gs);
    bit got;
    @(negedge clk);
    bus.data_in    = din[9:0];
    bus.delay      = dly[12:0];
    bus.mode       = md[0];
    bus.gain_sel   = gs[1:0];
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    got      = 1'b0;
    res      = -1;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_cnt++;
      if (bus.out_valid) begin
        got = 1'b1;
        res = int'(bus.data_out);
      end
    end
    if (!got) timeouts++;
    @(negedge clk);
    post_ov   = int'(bus.out_valid);
    post_busy = int'(bus.busy);
  endtask

  initial begin
    int mism;
    int pulses;
    int pulse_val;
    tests_run      = 0;
    tests_failed   = 0;
    timeouts       = 0;
    rst_n          = 1'b0;
    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    bus.delay      = '0;
    bus.mode       = 1'b0;
    bus.gain_sel   = '0;
    repeat (3) @(negedge clk);

    chk("rst_data_out", int'(bus.data_out), 512);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    rst_n = 1'b1;

    // Pass-through with timing.
    send(700, 0, 0, 0);
    chk("pass_out", res, 700);
    chk("pass_latency", lat, 4);
    chk("pass_busy_cycles", busy_cnt, 4);
    chk("pass_busy_after", post_busy, 0);
    chk("pass_valid_one_cycle", post_ov, 0);

    // Feed-forward echo.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(in3[i], 3, 0, 0);
      chk($sformatf("echo_%0d", i), res, exp3[i]);
    end

    // Feedback reverb.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send(in4[i], 2, 1, 0);
      chk($sformatf("reverb_%0d", i), res, exp4[i]);
    end

    // Saturation, both rails.
    do_reset();
    send(1023, 1, 0, 0);
    chk("sat_hi_0", res, 1023);
    send(1023, 1, 0, 0);
    chk("sat_hi_1", res, 1023);
    do_reset();
    send(0, 1, 0, 0);
    chk("sat_lo_0", res, 0);
    send(0, 1, 0, 0);
    chk("sat_lo_1", res, 0);

    // Gain 1/16 on a delay-1 echo: 100 >>> 4 = 6.
    do_reset();
    send(612, 1, 0, 3);
    send(512, 1, 0, 3);
    chk("gain16", res, 518);

    // Maximum delay with wrap; impulses at index 0 and 8189.
    do_reset();
    mism = 0;
    for (int i = 0; i <= 8192; i++) begin
      int din;
      int ex;
      din = (i == 0 || i == 8189) ? 612 : 512;
      ex  = (i == 0 || i == 8189) ? 612 : (i == 8191) ? 562 : 512;
      send(din, 8191, 0, 0);
      if (i == 8190) chk("wrap_8190", res, 512);
      else if (i == 8191) chk("wrap_8191", res, 562);
      else if (i == 8192) chk("wrap_8192", res, 512);
      else if (res != ex) mism++;
    end
    chk("wrap_other_mismatches", mism, 0);

    // Overrun: second strobe two cycles after the first.
    @(negedge clk);
    bus.data_in = 10'd600; bus.delay = '0; bus.mode = 1'b0; bus.gain_sel = '0;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    @(negedge clk);
    bus.data_in = 10'd900;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    pulses = 0;
    pulse_val = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        pulses++;
        pulse_val = int'(bus.data_out);
      end
    end
    chk("ovr_pulses", pulses, 1);
    chk("ovr_value", pulse_val, 600);
    chk("ovr_flag", int'(bus.overrun), 1);
    send(700, 0, 0, 0);
    chk("ovr_next_out", res, 700);
    chk("ovr_sticky", int'(bus.overrun), 1);

    // Reset while the sample sits in WAIT.
    @(negedge clk);
    bus.data_in = 10'd800; bus.delay = '0;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_data_out", int'(bus.data_out), 512);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_overrun", int'(bus.overrun), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    chk("midrst_no_output", pulses, 0);

    // Cold buffer: address 8189 still holds the old impulse.
    send(512, 3, 0, 0);
    chk("cold_tap", res, 512);

    chk("timeouts", timeouts, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
